// File: rtl/kulisch_to_fp16_pkg.sv
// kulisch_pkg: shared Kulisch accumulator constants, fp16 encoding constants and FSM state type
package kulisch_pkg;
    localparam int AWIDTH = 91;
    localparam int FRAC_BITS = 48;
    localparam int SEG_W = 16;
    localparam int NSEG = (AWIDTH + SEG_W - 1) / SEG_W;
    localparam int PW = $clog2(AWIDTH);
    localparam int SW = $clog2(NSEG);
    localparam int FP16_BIAS = 15;
    localparam int FP16_EMIN = -14;
    localparam logic [15:0] FP16_INF = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;
    typedef enum logic [2:0] {IDLE, ABS, SCAN, ROUND, OUT} kstate_t;
endpackage

// File: rtl/kulisch_to_fp16_if.sv
// kulisch_to_fp16_if: valid/ready accumulator input and fp16 result output bundle
interface kulisch_to_fp16_if;
    import kulisch_pkg::*;
    logic i_valid;
    logic i_ready;
    logic [AWIDTH-1:0] i_acc;
    logic o_valid;
    logic o_ready;
    logic [15:0] o_fp16;
    logic o_overflow;
    logic o_underflow;
    logic o_inexact;
    modport master (
        output i_valid, i_acc, o_ready,
        input  i_ready, o_valid, o_fp16, o_overflow, o_underflow, o_inexact
    );
    modport slave (
        input  i_valid, i_acc, o_ready,
        output i_ready, o_valid, o_fp16, o_overflow, o_underflow, o_inexact
    );
endinterface

// File: rtl/kulisch_seg_lead1.sv
// kulisch_seg_lead1: combinational leading-one priority encoder for one scan segment
module kulisch_seg_lead1 #(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] seg,
    output logic nz,
    output logic [$clog2(SEG_W)-1:0] idx
);
    localparam int IW = $clog2(SEG_W);
    assign nz = |seg;
    // highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        idx = '0;
        for (int i = 0; i < SEG_W; i++)
            if (seg[i]) idx = IW'(i);
    end
endmodule

// File: rtl/kulisch_to_fp16.sv
// kulisch_to_fp16: RNE conversion of a Kulisch accumulator to binary16; define FP16_OVF_SAT_EN to saturate overflow to max finite
module kulisch_to_fp16
    import kulisch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    kulisch_to_fp16_if.slave bus
);
`ifdef FP16_OVF_SAT_EN
    localparam logic [14:0] OVF_MAG = FP16_MAXF[14:0];
`else
    localparam logic [14:0] OVF_MAG = FP16_INF[14:0];
`endif
    kstate_t state, state_nx;
    logic [AWIDTH-1:0] mag;
    logic sign, zero_f;
    logic [SW-1:0] seg;
    logic [PW-1:0] p;
    logic [NSEG*SEG_W-1:0] mag_pad;
    logic [SEG_W-1:0] seg_bits;
    logic seg_nz;
    logic [$clog2(SEG_W)-1:0] seg_idx;
    logic normal, guard, sticky, rup, ovf;
    logic [PW-1:0] b, ef;
    logic [9:0] mant;
    logic [PW+9:0] sum;
    logic [15:0] res, fp16_r;
    logic ovf_r, unf_r, inx_r;

    assign mag_pad = {{(NSEG*SEG_W-AWIDTH){1'b0}}, mag};
    assign seg_bits = mag_pad[seg*SEG_W +: SEG_W];

    kulisch_seg_lead1 #(.SEG_W(SEG_W)) u_lead (
        .seg(seg_bits),
        .nz(seg_nz),
        .idx(seg_idx)
    );

    assign bus.i_ready = state == IDLE;
    assign bus.o_valid = state == OUT;
    assign bus.o_fp16 = fp16_r;
    assign bus.o_overflow = ovf_r;
    assign bus.o_underflow = unf_r;
    assign bus.o_inexact = inx_r;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next-state: scan stops at the first nonzero segment or after segment 0
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.i_valid) state_nx = ABS;
            ABS:     state_nx = SCAN;
            SCAN:    if (seg_nz || seg == '0) state_nx = ROUND;
            ROUND:   state_nx = OUT;
            OUT:     if (bus.o_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // rounding: b is the weight index of the result LSB (fixed at 2^-24 for subnormals)
    always_comb begin
        normal = p >= PW'(FRAC_BITS + FP16_EMIN);
        b = normal ? p - PW'(10) : PW'(FRAC_BITS + FP16_EMIN - 10);
        ef = normal ? p - PW'(FRAC_BITS - FP16_BIAS) : '0;
        mant = 10'(mag >> b);
        guard = mag[b - PW'(1)];
        sticky = |(mag & ((AWIDTH'(1) << (b - PW'(1))) - AWIDTH'(1)));
        rup = guard && (sticky || mant[0]);
        sum = {ef, mant} + (PW+10)'(rup);
        ovf = sum[PW+9:10] >= PW'(31);
        res = zero_f ? '0 : {sign, ovf ? OVF_MAG : sum[14:0]};
    end

    // datapath: capture, absolute value, segment scan, registered result
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mag <= '0;
            sign <= 1'b0;
            zero_f <= 1'b0;
            seg <= '0;
            p <= '0;
            fp16_r <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
            inx_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_valid) mag <= bus.i_acc;
                ABS: begin
                    sign <= mag[AWIDTH-1];
                    mag <= mag[AWIDTH-1] ? -mag : mag;
                    seg <= SW'(NSEG - 1);
                    zero_f <= 1'b0;
                end
                SCAN: begin
                    if (seg_nz) p <= PW'(seg * SEG_W) + PW'(seg_idx);
                    else if (seg == '0) zero_f <= 1'b1;
                    else seg <= seg - SW'(1);
                end
                ROUND: begin
                    fp16_r <= res;
                    ovf_r <= !zero_f && ovf;
                    unf_r <= !zero_f && !ovf && sum[PW+9:10] == '0;
                    inx_r <= !zero_f && (ovf || guard || sticky);
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_kulisch_to_fp16.sv
// tb_kulisch_to_fp16: directed and randomized checks of kulisch_to_fp16 against an arithmetic rounding model
module tb_kulisch_to_fp16;
    import kulisch_pkg::*;
`ifdef FP16_OVF_SAT_EN
    localparam logic [14:0] OVF = 15'h7BFF;
`else
    localparam logic [14:0] OVF = 15'h7C00;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    kulisch_to_fp16_if bus();
    kulisch_to_fp16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // value = acc * 2^-48; rounded in units of the target ulp by remainder-vs-half comparison
    function automatic void model(input logic [90:0] acc, output logic [15:0] fp,
                                  output logic of, output logic uf, output logic ix, output int lat);
        logic sgn;
        logic [90:0] m;
        logic [127:0] q, rem, half;
        int p, e, s;
        sgn = acc[90];
        m = sgn ? -acc : acc;
        fp = '0;
        of = 1'b0;
        uf = 1'b0;
        ix = 1'b0;
        lat = 8;
        if (m == '0) return;
        p = 0;
        for (int i = 0; i < 91; i++) if (m[i]) p = i;
        lat = 2 + (5 - p / 16) + 1;
        e = (p - 48 < -14) ? -14 : p - 48;
        s = e - 10 + 48;
        q = 128'(m) >> s;
        rem = 128'(m) - (q << s);
        half = 128'(1) << (s - 1);
        ix = rem != '0;
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == 128'd2048) begin
            q = 128'd1024;
            e = e + 1;
        end
        if (q < 128'd1024) fp = {sgn, 15'(q)};
        else if (e + 15 >= 31) begin
            of = 1'b1;
            ix = 1'b1;
            fp = {sgn, OVF};
        end else fp = {sgn, 5'(e + 15), 10'(q - 128'd1024)};
        uf = fp[14:10] == 5'd0;
    endfunction

    task automatic convert(input logic [90:0] acc, output logic [15:0] fp, output logic of,
                           output logic uf, output logic ix, output int lat);
        int n = 0;
        while (!bus.i_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus.i_acc = acc;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        fp = bus.o_fp16;
        of = bus.o_overflow;
        uf = bus.o_underflow;
        ix = bus.o_inexact;
        if (bus.o_ready && bus.o_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({bus.i_ready, bus.o_valid, bus.o_fp16, bus.o_overflow, bus.o_underflow, bus.o_inexact} !== {2'b10, 16'h0, 3'b000}) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b fp=%h flags=%b%b%b, expected rdy=1 vld=0 fp=0000 flags=000",
                     bus.i_ready, bus.o_valid, bus.o_fp16, bus.o_overflow, bus.o_underflow, bus.o_inexact);
        end
    endtask

    task automatic test_directed();
        logic [90:0] acc [14];
        logic [18:0] want [14];
        int want_lat [14];
        logic [15:0] fp;
        logic of, uf, ix;
        int lat;
        acc[0] = 91'(1) << 48;                              want[0] = {16'h3C00, 3'b000};      want_lat[0] = 5;
        acc[1] = -(91'(5) << 47);                           want[1] = {16'hC100, 3'b000};      want_lat[1] = 5;
        acc[2] = '0;                                        want[2] = {16'h0000, 3'b000};      want_lat[2] = 8;
        acc[3] = (91'(1) << 48) | (91'(1) << 37);           want[3] = {16'h3C00, 3'b001};      want_lat[3] = 5;
        acc[4] = acc[3] | (91'(1) << 38);                   want[4] = {16'h3C02, 3'b001};      want_lat[4] = 5;
        acc[5] = 91'(1) << 24;                              want[5] = {16'h0001, 3'b010};      want_lat[5] = 7;
        acc[6] = 91'(1);                                    want[6] = {16'h0000, 3'b011};      want_lat[6] = 8;
        acc[7] = 91'(1) << 64;                              want[7] = {1'b0, OVF, 3'b101};     want_lat[7] = 4;
        acc[8] = -(91'(1) << 90);                           want[8] = {1'b1, OVF, 3'b101};     want_lat[8] = 3;
        acc[9] = 91'(65504) << 48;                          want[9] = {16'h7BFF, 3'b000};      want_lat[9] = 5;
        acc[10] = 91'(65520) << 48;                         want[10] = {1'b0, OVF, 3'b101};    want_lat[10] = 5;
        acc[11] = 91'(1) << 34;                             want[11] = {16'h0400, 3'b000};     want_lat[11] = 6;
        acc[12] = (91'(1) << 34) - 91'(1);                  want[12] = {16'h0400, 3'b001};     want_lat[12] = 6;
        acc[13] = -91'(1);                                  want[13] = {16'h8000, 3'b011};     want_lat[13] = 8;
        for (int i = 0; i < 14; i++) begin
            convert(acc[i], fp, of, uf, ix, lat);
            tests++;
            if ({fp, of, uf, ix} !== want[i]) begin
                fails++;
                $display("FAIL directed[%0d] result: got %h/%b%b%b, expected %h/%b", i, fp, of, uf, ix, want[i][18:3], want[i][2:0]);
            end
            tests++;
            if (lat !== want_lat[i]) begin
                fails++;
                $display("FAIL directed[%0d] latency: got %0d, expected %0d", i, lat, want_lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [90:0] acc;
        logic [15:0] fp, efp;
        logic of, uf, ix, eof, euf, eix;
        int lat, elat;
        for (int i = 0; i < 150; i++) begin
            acc = 91'({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 1) == 1) acc = acc & ~((91'(1) << $urandom_range(0, 60)) - 91'(1));
            acc = acc >> $urandom_range(0, 90);
            if ($urandom_range(0, 1) == 1) acc = -acc;
            model(acc, efp, eof, euf, eix, elat);
            convert(acc, fp, of, uf, ix, lat);
            tests++;
            if ({fp, of, uf, ix} !== {efp, eof, euf, eix}) begin
                fails++;
                $display("FAIL random result acc=%h: got %h/%b%b%b, expected %h/%b%b%b", acc, fp, of, uf, ix, efp, eof, euf, eix);
            end
            tests++;
            if (lat !== elat) begin
                fails++;
                $display("FAIL random latency acc=%h: got %0d, expected %0d", acc, lat, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] fp;
        logic of, uf, ix;
        int lat;
        bus.o_ready = 1'b0;
        convert(-(91'(5) << 47), fp, of, uf, ix, lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tests++;
            if ({bus.o_valid, bus.i_ready, bus.o_fp16, bus.o_inexact} !== {2'b10, 16'hC100, 1'b0}) begin
                fails++;
                $display("FAIL backpressure cycle %0d: vld=%b rdy=%b fp=%h, expected vld=1 rdy=0 fp=c100", c, bus.o_valid, bus.i_ready, bus.o_fp16);
            end
        end
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({bus.o_valid, bus.i_ready} !== 2'b01) begin
            fails++;
            $display("FAIL backpressure release: vld=%b rdy=%b, expected vld=0 rdy=1", bus.o_valid, bus.i_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] fp;
        logic of, uf, ix;
        int lat;
        bus.i_acc = 91'(1) << 48;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.i_ready, bus.o_valid} !== 2'b10) begin
            fails++;
            $display("FAIL reset_mid async: rdy=%b vld=%b, expected rdy=1 vld=0", bus.i_ready, bus.o_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if ({bus.i_ready, bus.o_valid, bus.o_fp16} !== {2'b10, 16'h0}) begin
            fails++;
            $display("FAIL reset_mid next cycle: rdy=%b vld=%b fp=%h, expected rdy=1 vld=0 fp=0000", bus.i_ready, bus.o_valid, bus.o_fp16);
        end
        convert(91'(1) << 24, fp, of, uf, ix, lat);
        tests++;
        if ({fp, of, uf, ix, 8'(lat)} !== {16'h0001, 3'b010, 8'd7}) begin
            fails++;
            $display("FAIL reset_mid followup: got %h/%b%b%b lat %0d, expected 0001/010 lat 7", fp, of, uf, ix, lat);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        logic [15:0] fp2 = '0;
        bus.o_ready = 1'b1;
        bus.i_acc = 91'(1) << 48;
        bus.i_valid = 1'b1;
        for (int c = 0; c < 40 && second < 0; c++) begin
            @(posedge clk); #1;
            if (bus.o_valid) begin
                if (first < 0) first = c;
                else begin
                    second = c;
                    fp2 = bus.o_fp16;
                end
            end
        end
        bus.i_valid = 1'b0;
        tests++;
        if (first < 0 || second < 0 || second - first != 7) begin
            fails++;
            $display("FAIL back_to_back interval: got %0d (first %0d second %0d), expected 7", second - first, first, second);
        end
        tests++;
        if (fp2 !== 16'h3C00) begin
            fails++;
            $display("FAIL back_to_back second result: got %h, expected 3c00", fp2);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_acc = '0;
        bus.o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
